led_pattern_engine: RTL and testbench



---
 rtl/led_pattern_engine_pkg.sv | 28 ++
 rtl/led_ramp_gen.sv | 76 +++++++
 rtl/led_pattern_engine.sv | 131 +++++++++++++
 tb/tb_led_pattern_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_engine_pkg.sv
// Shared definitions for the LED pattern engine.
// Contents:
//   mode_t   - pattern select encodings driven onto the 'mode' port
//   dir_t    - ramp / scan direction
//   PWM_MAX  - full-scale brightness for the default 8-bit PWM
//   pwm_max  - full-scale brightness for any PWM width
package led_pattern_engine_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE  = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int DEFAULT_PWM_BITS = 8;
    localparam int PWM_MAX          = (1 << DEFAULT_PWM_BITS) - 1;

    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_ramp_gen.sv
// Triangle brightness ramp used by the ROTATE and BREATHE patterns.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   tick  - advance the ramp by one STEP (already qualified by the caller)
//   clear - restart the ramp at level 0 going up
//   level - current brightness, 0 .. 2^PWM_BITS-1
//   wrap  - high during the tick that brings the ramp back down to 0;
//           the caller registers it into its frame pulse
module led_ramp_gen
    import led_pattern_engine_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                clear,
    output logic [PWM_BITS-1:0] level,
    output logic                wrap
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP_V    = PWM_BITS'(STEP);
    // Threshold at which a further STEP would pass full scale.
    localparam logic [PWM_BITS-1:0] UP_LIMIT  = LEVEL_MAX - STEP_V;

    dir_t                dir;
    dir_t                dir_next;
    logic [PWM_BITS-1:0] level_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            dir   <= DIR_UP;
        end else begin
            level <= level_next;
            dir   <= dir_next;
        end
    end

    // Saturate at both ends so the ramp never wraps around; the bottom
    // endpoint also marks the end of a fade frame.
    always_comb begin
        level_next = level;
        dir_next   = dir;
        wrap       = 1'b0;
        if (clear) begin
            level_next = '0;
            dir_next   = DIR_UP;
        end else if (tick) begin
            case (dir)
                DIR_UP: begin
                    if (level >= UP_LIMIT) begin
                        level_next = LEVEL_MAX;
                        dir_next   = DIR_DOWN;
                    end else begin
                        level_next = level + STEP_V;
                    end
                end
                DIR_DOWN: begin
                    if (level <= STEP_V) begin
                        level_next = '0;
                        dir_next   = DIR_UP;
                        wrap       = 1'b1;
                    end else begin
                        level_next = level - STEP_V;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// PWM-dimmed LED pattern engine: rotating fade, breathing and bounce scan.
// Ports:
//   clk        - system clock (PLL output)
//   rst        - synchronous active-high reset
//   tick       - single-cycle prescaler enable that advances the pattern
//   mode       - 0 ROTATE, 1 BREATHE, 2 SCAN, 3 OFF
//   led        - registered LED drive, 1 = on
//   frame_done - one-cycle pulse at the end of a fade frame or scan sweep
module led_pattern_engine
    import led_pattern_engine_pkg::*;
#(
    parameter int NUM_LEDS = 5,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                frame_done
);

    localparam int              POS_W    = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    pos_next;
    dir_t                scan_dir;
    dir_t                scan_dir_next;
    mode_t               mode_in;
    mode_t               mode_q;
    logic                mode_change;
    logic                ramp_tick;
    logic                ramp_wrap;
    logic                scan_wrap;
    logic                frame_next;
    logic [NUM_LEDS-1:0] led_next;

    assign mode_in     = mode_t'(mode);
    assign mode_change = (mode_in != mode_q);
    // A tick coinciding with a mode change is dropped; the change wins.
    assign ramp_tick   = tick && !mode_change &&
                         ((mode_q == MODE_ROTATE) || (mode_q == MODE_BREATHE));

    led_ramp_gen #(
        .PWM_BITS (PWM_BITS),
        .STEP     (STEP)
    ) u_ramp (
        .clk   (clk),
        .rst   (rst),
        .tick  (ramp_tick),
        .clear (mode_change),
        .level (level),
        .wrap  (ramp_wrap)
    );

    // mode_q follows the input during reset so that releasing reset does
    // not look like a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt    <= '0;
            mode_q     <= mode_in;
            pos        <= '0;
            scan_dir   <= DIR_UP;
            led        <= '0;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            mode_q     <= mode_in;
            pos        <= pos_next;
            scan_dir   <= scan_dir_next;
            led        <= led_next;
            frame_done <= frame_next;
        end
    end

    // Position / scan direction. The scan flips direction on arriving at an
    // endpoint, so each endpoint is displayed for exactly one tick.
    always_comb begin
        pos_next      = pos;
        scan_dir_next = scan_dir;
        scan_wrap     = 1'b0;
        if (mode_change) begin
            pos_next      = '0;
            scan_dir_next = DIR_UP;
        end else if (tick) begin
            case (mode_q)
                MODE_ROTATE: begin
                    if (ramp_wrap) begin
                        pos_next = (pos == LAST_POS) ? '0 : pos + 1'b1;
                    end
                end
                MODE_SCAN: begin
                    if (scan_dir == DIR_UP) begin
                        pos_next = pos + 1'b1;
                        if (pos == LAST_POS - 1'b1) begin
                            scan_dir_next = DIR_DOWN;
                        end
                    end else begin
                        pos_next = pos - 1'b1;
                        if (pos == POS_W'(1)) begin
                            scan_dir_next = DIR_UP;
                            scan_wrap     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ramp_wrap can only fire on a qualified ramp tick, so neither source is
    // active in OFF.
    assign frame_next = ramp_wrap | scan_wrap;

    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q)
                MODE_ROTATE:  led_next[i] = (POS_W'(i) == pos) && (pwm_cnt < level);
                MODE_BREATHE: led_next[i] = (pwm_cnt < level);
                MODE_SCAN:    led_next[i] = (POS_W'(i) == pos);
                default:      led_next[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine (NUM_LEDS=5,
// PWM_BITS=8, STEP=51). Duty cycles are measured by counting LED-on samples
// over one full 256-cycle PWM period.
module tb_led_pattern_engine;
    import led_pattern_engine_pkg::*;

    localparam int NUM_LEDS = 5;
    localparam int PWM_BITS = 8;
    localparam int STEP     = 51;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led;
    logic                frame_done;

    int assert_count = 0;
    int fail_count   = 0;
    int duty_cnt [NUM_LEDS];

    always #5 clk = ~clk;

    led_pattern_engine #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS),
        .STEP     (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .mode       (mode),
        .led        (led),
        .frame_done (frame_done)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick pulse; returns frame_done as seen right after the tick edge.
    task automatic apply_stimulus(output logic fd);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        fd   = frame_done;
        tick = 1'b0;
    endtask

    task automatic set_mode(input mode_t m);
        @(negedge clk);
        mode = m;
        idle(2);
    endtask

    task automatic measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) duty_cnt[i] = 0;
        idle(2);
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < NUM_LEDS; i++) if (led[i]) duty_cnt[i]++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic fd;
        int   fd_total;
        int   breathe_lv [10] = '{51, 102, 153, 204, 255, 204, 153, 102, 51, 0};
        int   scan_pos [8]    = '{1, 2, 3, 4, 3, 2, 1, 0};

        // Reset with tick held high
        rst  = 1'b1;
        tick = 1'b1;
        mode = MODE_BREATHE;
        idle(3);
        check_output("reset_led", 32'(led), 0);
        check_output("reset_frame_done", 32'(frame_done), 0);
        check_output("reset_pwm_cnt", 32'(dut.pwm_cnt), 0);
        rst  = 1'b0;
        tick = 1'b0;
        check_output("release_pwm_cnt", 32'(dut.pwm_cnt), 0);
        @(negedge clk);
        check_output("pwm_cnt_first_step", 32'(dut.pwm_cnt), 1);
        check_output("pwm_max_const", 32'(PWM_MAX), 255);

        // BREATHE ramp
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(fd);
            check_output($sformatf("breathe_fd_%0d", k + 1), 32'(fd), (k == 9) ? 1 : 0);
            check_output($sformatf("breathe_level_%0d", k + 1), 32'(dut.level), breathe_lv[k]);
            if (k == 9) begin
                @(negedge clk);
                check_output("breathe_fd_width", 32'(frame_done), 0);
            end
            measure_duty();
            if (k == 1) begin
                for (int i = 0; i < NUM_LEDS; i++)
                    check_output($sformatf("breathe_duty102_led%0d", i), 32'(duty_cnt[i]), 102);
            end else begin
                check_output($sformatf("breathe_duty_%0d", k + 1),
                             32'(duty_cnt[k % NUM_LEDS]), breathe_lv[k]);
            end
        end

        // ROTATE: 50 ticks = 5 fade frames, pos walks 0..4 and back to 0
        set_mode(MODE_ROTATE);
        check_output("rotate_start_pos", 32'(dut.pos), 0);
        fd_total = 0;
        for (int k = 1; k <= 50; k++) begin
            apply_stimulus(fd);
            fd_total += int'(fd);
            if (k == 5) begin
                measure_duty();
                for (int i = 0; i < NUM_LEDS; i++)
                    check_output($sformatf("rotate_max_led%0d", i), 32'(duty_cnt[i]),
                                 (i == 0) ? 255 : 0);
            end
            if (k == 10) begin
                check_output("rotate_pos_after10", 32'(dut.pos), 1);
                check_output("rotate_fd_after10", 32'(fd_total), 1);
            end
            if (k == 11) begin
                measure_duty();
                for (int i = 0; i < NUM_LEDS; i++)
                    check_output($sformatf("rotate_pos1_led%0d", i), 32'(duty_cnt[i]),
                                 (i == 1) ? 51 : 0);
            end
        end
        check_output("rotate_pos_after50", 32'(dut.pos), 0);
        check_output("rotate_fd_after50", 32'(fd_total), 5);
        check_output("rotate_level_after50", 32'(dut.level), 0);

        // SCAN bounce
        set_mode(MODE_SCAN);
        check_output("scan_start_led", 32'(led), 1);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(fd);
            check_output($sformatf("scan_fd_%0d", k + 1), 32'(fd), (k == 7) ? 1 : 0);
            @(negedge clk);
            check_output($sformatf("scan_led_%0d", k + 1), 32'(led), 32'(1) << scan_pos[k]);
            if (k == 7) check_output("scan_fd_width", 32'(frame_done), 0);
        end

        // Mode switch with a tick in the same cycle
        set_mode(MODE_BREATHE);
        repeat (3) apply_stimulus(fd);
        check_output("switch_pre_level", 32'(dut.level), 153);
        @(negedge clk);
        mode = MODE_ROTATE;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_output("switch_fd", 32'(frame_done), 0);
        check_output("switch_level_cleared", 32'(dut.level), 0);
        check_output("switch_pos_cleared", 32'(dut.pos), 0);
        apply_stimulus(fd);
        check_output("switch_next_level", 32'(dut.level), 51);
        measure_duty();
        check_output("switch_next_duty", 32'(duty_cnt[0]), 51);

        // OFF freezes everything and never pulses frame_done
        repeat (3) apply_stimulus(fd);
        check_output("off_pre_level", 32'(dut.level), 204);
        set_mode(MODE_OFF);
        fd_total = 0;
        repeat (20) begin
            apply_stimulus(fd);
            fd_total += int'(fd);
        end
        check_output("off_fd_count", 32'(fd_total), 0);
        check_output("off_level_frozen", 32'(dut.level), 0);
        measure_duty();
        fd_total = 0;
        for (int i = 0; i < NUM_LEDS; i++) fd_total += duty_cnt[i];
        check_output("off_led_on_count", 32'(fd_total), 0);
        set_mode(MODE_ROTATE);
        check_output("off_return_level", 32'(dut.level), 0);
        apply_stimulus(fd);
        check_output("off_return_next_level", 32'(dut.level), 51);

        // Reset in the middle of a scan
        set_mode(MODE_SCAN);
        repeat (3) apply_stimulus(fd);
        check_output("midscan_pos", 32'(dut.pos), 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midscan_reset_pos", 32'(dut.pos), 0);
        check_output("midscan_reset_led", 32'(led), 0);
        @(negedge clk);
        check_output("midscan_after_reset_led", 32'(led), 1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
